// File: rtl/spi_controller.sv
// Full-duplex SPI master: one DATA_WIDTH word per transaction, MSB first, with the
// SPI mode (CPOL/CPHA) and target chip select latched per transfer. All outputs are registered.
module spi_controller #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned DATA_PERIOD = 100,
  parameter int unsigned NUM_SEL     = 1,
  localparam int unsigned SelW       = (NUM_SEL > 1) ? $clog2(NUM_SEL) : 1
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  trigger_in,
  input  logic [SelW-1:0]       sel_idx_in,
  input  logic                  cpol_in,
  input  logic                  cpha_in,
  input  logic                  chip_data_in,
  output logic                  data_out,
  output logic                  data_clk_out,
  output logic [NUM_SEL-1:0]    sel_out,
  output logic                  busy_out,
  output logic [DATA_WIDTH-1:0] rx_data_out,
  output logic                  rx_valid_out
);

  // Odd periods round down; anything below 2 behaves as 2.
  localparam int unsigned Half     = (DATA_PERIOD < 2) ? 1 : DATA_PERIOD / 2;
  localparam int unsigned CntW     = (Half > 1) ? $clog2(Half) : 1;
  localparam int unsigned NumEdges = 2 * DATA_WIDTH;
  localparam int unsigned EdgeW    = $clog2(NumEdges + 1);
  localparam logic [CntW-1:0]  CntMax   = CntW'(Half - 1);
  localparam logic [EdgeW-1:0] EdgeLast = EdgeW'(NumEdges);

  typedef enum logic [1:0] {StIdle, StXfer, StHold} state_e;

  state_e                  state_q, state_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [EdgeW-1:0]        edge_q, edge_d;
  logic [DATA_WIDTH-1:0]   tx_q, tx_d;
  logic [DATA_WIDTH-1:0]   rx_q, rx_d;
  logic                    cpol_q, cpol_d;
  logic                    cpha_q, cpha_d;
  logic                    sclk_q, sclk_d;
  logic                    mosi_q, mosi_d;
  logic [NUM_SEL-1:0]      sel_q, sel_d;
  logic                    busy_q, busy_d;
  logic [DATA_WIDTH-1:0]   rx_data_q, rx_data_d;
  logic                    rx_valid_q, rx_valid_d;
  logic                    sel_ok;

  assign sel_ok = (32'(sel_idx_in) < NUM_SEL);

  // Next-state logic: transfer sequencing, SCLK generation, shift registers.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    edge_d     = edge_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    cpol_d     = cpol_q;
    cpha_d     = cpha_q;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    sel_d      = sel_q;
    busy_d     = busy_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        sclk_d = cpol_q;
        mosi_d = 1'b0;
        sel_d  = '1;
        busy_d = 1'b0;
        // The completion cycle (rx_valid high) still refuses a new request.
        if (trigger_in && sel_ok && !rx_valid_q) begin
          state_d = StXfer;
          cpol_d  = cpol_in;
          cpha_d  = cpha_in;
          sclk_d  = cpol_in;
          busy_d  = 1'b1;
          cnt_d   = '0;
          edge_d  = '0;
          rx_d    = '0;
          for (int unsigned i = 0; i < NUM_SEL; i++) begin
            sel_d[i] = (32'(sel_idx_in) != i);
          end
          // CPHA=0 presents the MSB before the first edge; CPHA=1 waits for edge 1.
          if (!cpha_in) begin
            mosi_d = data_in[DATA_WIDTH-1];
            tx_d   = data_in << 1;
          end else begin
            tx_d   = data_in;
          end
        end
      end

      StXfer: begin
        if (cnt_q == CntMax) begin
          cnt_d  = '0;
          sclk_d = ~sclk_q;
          edge_d = edge_q + 1'b1;
          if (!edge_q[0]) begin
            // Leading edge.
            if (!cpha_q) begin
              rx_d = {rx_q[DATA_WIDTH-2:0], chip_data_in};
            end else begin
              mosi_d = tx_q[DATA_WIDTH-1];
              tx_d   = tx_q << 1;
            end
          end else begin
            // Trailing edge.
            if (cpha_q) begin
              rx_d = {rx_q[DATA_WIDTH-2:0], chip_data_in};
            end else if (edge_d != EdgeLast) begin
              mosi_d = tx_q[DATA_WIDTH-1];
              tx_d   = tx_q << 1;
            end
          end
          if (edge_d == EdgeLast) begin
            state_d = StHold;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      StHold: begin
        if (cnt_q == CntMax) begin
          state_d    = StIdle;
          cnt_d      = '0;
          edge_d     = '0;
          sel_d      = '1;
          busy_d     = 1'b0;
          mosi_d     = 1'b0;
          rx_data_d  = rx_q;
          rx_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      edge_q     <= '0;
      tx_q       <= '0;
      rx_q       <= '0;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      sel_q      <= '1;
      busy_q     <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      edge_q     <= edge_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      cpol_q     <= cpol_d;
      cpha_q     <= cpha_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      sel_q      <= sel_d;
      busy_q     <= busy_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  assign data_out     = mosi_q;
  assign data_clk_out = sclk_q;
  assign sel_out      = sel_q;
  assign busy_out     = busy_q;
  assign rx_data_out  = rx_data_q;
  assign rx_valid_out = rx_valid_q;

endmodule

// File: tb/tb_spi_controller.sv
// Bench for spi_controller: three instances in lockstep (period 4 / two selects,
// period 5 / two selects, period 4 / three selects), checked cycle by cycle against
// waveforms computed from the edge-count arithmetic of an SPI transfer.
module tb_spi_controller;

  localparam int W     = 8;
  localparam int H     = 2;
  localparam int Total = (2 * W + 1) * H;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] data_s = '0;
  logic         trigger = 1'b0;
  logic         trig_c_only = 1'b0;
  logic [1:0]   sel2 = '0;
  logic         cpol_s = 1'b0;
  logic         cpha_s = 1'b0;
  logic         miso_rnd = 1'b0;
  logic         loop_en = 1'b0;
  logic         chip;

  logic         mosi_a, sclk_a, busy_a, rxv_a;
  logic         mosi_b, sclk_b, busy_b, rxv_b;
  logic         mosi_c, sclk_c, busy_c, rxv_c;
  logic [1:0]   sel_a, sel_b;
  logic [2:0]   sel_c;
  logic [W-1:0] rxd_a, rxd_b, rxd_c;
  logic [14:0]  pk_a, pk_b, pk_c;

  int n_tests = 0;
  int n_fail  = 0;
  int n_xfer  = 0;

  // Idle SCLK level and last received word the bench expects per instance group.
  logic         pol_ab = 1'b0, pol_c = 1'b0;
  logic [W-1:0] prev_ab = '0, prev_c = '0;

  always #5 clk = ~clk;

  assign chip = loop_en ? mosi_a : miso_rnd;

  // Packed view: {sel[2:0], busy, sclk, mosi, rx_valid, rx_data[7:0]}
  assign pk_a = {1'b1, sel_a, busy_a, sclk_a, mosi_a, rxv_a, rxd_a};
  assign pk_b = {1'b1, sel_b, busy_b, sclk_b, mosi_b, rxv_b, rxd_b};
  assign pk_c = {sel_c, busy_c, sclk_c, mosi_c, rxv_c, rxd_c};

  spi_controller #(.DATA_WIDTH(W), .DATA_PERIOD(4), .NUM_SEL(2)) u_a (
    .clk_in(clk), .rst_in(rst), .data_in(data_s), .trigger_in(trigger),
    .sel_idx_in(sel2[0]), .cpol_in(cpol_s), .cpha_in(cpha_s), .chip_data_in(chip),
    .data_out(mosi_a), .data_clk_out(sclk_a), .sel_out(sel_a), .busy_out(busy_a),
    .rx_data_out(rxd_a), .rx_valid_out(rxv_a)
  );

  spi_controller #(.DATA_WIDTH(W), .DATA_PERIOD(5), .NUM_SEL(2)) u_b (
    .clk_in(clk), .rst_in(rst), .data_in(data_s), .trigger_in(trigger),
    .sel_idx_in(sel2[0]), .cpol_in(cpol_s), .cpha_in(cpha_s), .chip_data_in(chip),
    .data_out(mosi_b), .data_clk_out(sclk_b), .sel_out(sel_b), .busy_out(busy_b),
    .rx_data_out(rxd_b), .rx_valid_out(rxv_b)
  );

  spi_controller #(.DATA_WIDTH(W), .DATA_PERIOD(4), .NUM_SEL(3)) u_c (
    .clk_in(clk), .rst_in(rst), .data_in(data_s), .trigger_in(trigger | trig_c_only),
    .sel_idx_in(sel2), .cpol_in(cpol_s), .cpha_in(cpha_s), .chip_data_in(chip),
    .data_out(mosi_c), .data_clk_out(sclk_c), .sel_out(sel_c), .busy_out(busy_c),
    .rx_data_out(rxd_c), .rx_valid_out(rxv_c)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (sel,busy,sclk,mosi,rxv,rxd)", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string what, input logic [14:0] ea, input logic [14:0] ec);
    check($sformatf("A %s", what), 32'(pk_a), 32'(ea));
    check($sformatf("B %s", what), 32'(pk_b), 32'(ea));
    check($sformatf("C %s", what), 32'(pk_c), 32'(ec));
  endtask

  function automatic logic [14:0] exp_idle(input logic pol, input logic [W-1:0] rxd);
    return {3'b111, 1'b0, pol, 1'b0, 1'b0, rxd};
  endfunction

  // Expected outputs c cycles after the acceptance cycle: edges done = c / H,
  // bit j is driven at the start (CPHA=0) or on edge 2j+1 (CPHA=1).
  function automatic logic [14:0] exp_act(input int c, input logic [W-1:0] d, input logic pol,
                                          input logic pha, input logic [2:0] sl,
                                          input logic [W-1:0] rprev, input logic [W-1:0] rnew);
    int   e;
    int   b;
    logic m;
    if (c >= Total) return {3'b111, 1'b0, pol, 1'b0, 1'b1, rnew};
    e = c / H;
    if (e > 2 * W) e = 2 * W;
    if (!pha) b = e / 2;
    else      b = (e == 0) ? -1 : (e - 1) / 2;
    if (b > W - 1) b = W - 1;
    m = (b < 0) ? 1'b0 : d[W-1-b];
    return {sl, 1'b1, pol ^ e[0], m, 1'b0, rprev};
  endfunction

  // miso_mode: 0 random, 1 loopback from MOSI, 2 constant one. rst_c >= 0 resets mid-transfer.
  task automatic run_xfer(input logic [W-1:0] d, input logic [1:0] s, input logic pol,
                          input logic pha, input int miso_mode, input int rst_c);
    logic         rec [0:63];
    logic [W-1:0] rx_exp;
    logic         c_act;
    logic [2:0]   sl_ab, sl_c;
    logic [14:0]  ea, ec;
    n_xfer++;
    c_act  = (s != 2'd3);
    sl_ab  = {1'b1, ~(2'b01 << s[0])};
    sl_c   = ~(3'b001 << s);
    rx_exp = '0;
    data_s = d; sel2 = s; cpol_s = pol; cpha_s = pha;
    trigger = 1'b1; trig_c_only = 1'b0;
    loop_en = (miso_mode == 1);
    @(negedge clk);
    trigger = 1'b0;
    for (int c = 0; c <= Total; c++) begin
      if (c == rst_c) begin
        rst = 1'b1; trigger = 1'b0;
        #1;
        check_all($sformatf("x%0d async reset", n_xfer), exp_idle(1'b0, '0), exp_idle(1'b0, '0));
        @(negedge clk);
        check_all($sformatf("x%0d reset held", n_xfer), exp_idle(1'b0, '0), exp_idle(1'b0, '0));
        rst = 1'b0;
        pol_ab = 1'b0; pol_c = 1'b0; prev_ab = '0; prev_c = '0;
        for (int i = 0; i < Total; i++) begin
          @(negedge clk);
          check_all($sformatf("x%0d after reset %0d", n_xfer, i), exp_idle(1'b0, '0),
                    exp_idle(1'b0, '0));
        end
        return;
      end
      if (c == Total) begin
        for (int k = 1; k <= 2 * W; k++) begin
          if (((k % 2) == 1) == (pha == 1'b0)) rx_exp = {rx_exp[W-2:0], rec[k*H-1]};
        end
      end
      ea = exp_act(c, d, pol, pha, sl_ab, prev_ab, rx_exp);
      ec = c_act ? exp_act(c, d, pol, pha, sl_c, prev_c, rx_exp) : exp_idle(pol_c, prev_c);
      check_all($sformatf("x%0d c=%0d", n_xfer, c), ea, ec);
      miso_rnd = (miso_mode == 2) ? 1'b1 : 1'($urandom);
      rec[c]   = loop_en ? ea[9] : miso_rnd;
      // Requests mid-transfer and on the completion cycle must be ignored.
      if (c == 4 || c == Total) begin
        trigger = 1'b1; sel2 = 2'd3;
      end else begin
        trigger = 1'b0;
      end
      data_s = W'($urandom); cpol_s = 1'($urandom); cpha_s = 1'($urandom);
      @(negedge clk);
    end
    trigger = 1'b0;
    prev_ab = rx_exp;
    pol_ab  = pol;
    if (c_act) begin
      prev_c = rx_exp;
      pol_c  = pol;
    end
    check_all($sformatf("x%0d after done", n_xfer), exp_idle(pol_ab, prev_ab),
              exp_idle(pol_c, prev_c));
  endtask

  // Idle cycles; instance C alone sees requests with an out-of-range select.
  task automatic idle_gap(input int n);
    for (int i = 0; i < n; i++) begin
      check_all($sformatf("gap after x%0d, %0d", n_xfer, i), exp_idle(pol_ab, prev_ab),
                exp_idle(pol_c, prev_c));
      sel2 = 2'd3; trigger = 1'b0; trig_c_only = 1'($urandom);
      @(negedge clk);
    end
    trig_c_only = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_all("in reset", exp_idle(1'b0, '0), exp_idle(1'b0, '0));
    rst = 1'b0;
    @(negedge clk);
    check_all("after reset", exp_idle(1'b0, '0), exp_idle(1'b0, '0));

    run_xfer(8'hA5, 2'd0, 1'b0, 1'b0, 1, -1);  // mode 0, loopback
    run_xfer(8'h3C, 2'd1, 1'b1, 1'b1, 2, -1);  // mode 3, MISO high, back to back
    idle_gap(3);
    run_xfer(8'h5A, 2'd3, 1'b0, 1'b1, 0, -1);  // C sees invalid select
    run_xfer(8'h96, 2'd2, 1'b1, 1'b0, 0, -1);  // C uses select 2
    idle_gap(2);
    run_xfer(8'hC3, 2'd0, 1'b0, 1'b1, 0, 7);   // mode 1, reset after edge 3
    run_xfer(8'h0F, 2'd1, 1'b0, 1'b1, 1, -1);

    for (int i = 0; i < 20; i++) begin
      run_xfer(W'($urandom), 2'($urandom), 1'($urandom), 1'($urandom),
               int'($urandom_range(0, 2)), -1);
      if ($urandom_range(0, 1) == 1) idle_gap(int'($urandom_range(1, 4)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
